// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage, owns pc_F and the F/D register, single outstanding imem request
// Ports: clk/rst (async active-high), stall/flush/flush_pc from hazard/execute,
//        imem_req/imem_addr/imem_ready request side, imem_rvalid/imem_rdata response side,
//        pc_F fetch PC, ir_FD/pc_FD/valid_FD F/D pipeline register.
// Optional: define FETCH_PERF_EN to add fetch_bubbles, a saturating count of data-starved bubbles.
module fetch_unit #(
   parameter int               Width    = 32,
   parameter logic [Width-1:0] RESET_PC = '0,
   parameter logic [Width-1:0] NOP      = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic [Width-1:0] flush_pc,
   output logic             imem_req,
   output logic [Width-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [Width-1:0] imem_rdata,
   output logic [Width-1:0] pc_F,
   output logic [Width-1:0] ir_FD,
   output logic [Width-1:0] pc_FD,
   output logic             valid_FD
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]      fetch_bubbles
`endif
);
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
   state_t           state, state_n;
   logic [Width-1:0] req_pc, hold_ir, hold_pc;
   logic             hold_full, accept, resp;
   // a full hold buffer means the response is parked, so no new request may go out
   assign imem_req  = !rst && state == S_REQ && !hold_full && !flush;
   assign imem_addr = pc_F;
   assign accept    = imem_req && imem_ready;
   assign resp      = state == S_WAIT && imem_rvalid;
   always_comb begin
      state_n = state;
      if (accept)
         state_n = S_WAIT;
      else if (state != S_REQ && imem_rvalid)
         state_n = S_REQ;
      else if (state == S_WAIT && flush)
         state_n = S_DROP;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_REQ;
         pc_F      <= RESET_PC;
         req_pc    <= '0;
         hold_full <= 1'b0;
         hold_ir   <= '0;
         hold_pc   <= '0;
         ir_FD     <= NOP;
         pc_FD     <= '0;
         valid_FD  <= 1'b0;
      end else begin
         state <= state_n;
         pc_F  <= flush ? flush_pc : accept ? pc_F + Width'(4) : pc_F;
         if (accept)
            req_pc <= pc_F;
         if (flush) begin
            ir_FD     <= NOP;
            valid_FD  <= 1'b0;
            hold_full <= 1'b0;
         end else if (stall) begin
            // F/D frozen: park an arriving word with its PC until the stall lifts
            if (resp) begin
               hold_full <= 1'b1;
               hold_ir   <= imem_rdata;
               hold_pc   <= req_pc;
            end
         end else if (hold_full) begin
            ir_FD     <= hold_ir;
            pc_FD     <= hold_pc;
            valid_FD  <= 1'b1;
            hold_full <= 1'b0;
         end else if (resp) begin
            ir_FD    <= imem_rdata;
            pc_FD    <= req_pc;
            valid_FD <= 1'b1;
         end else begin
            ir_FD    <= NOP;
            valid_FD <= 1'b0;
         end
      end
   end
`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_bubbles <= '0;
      else if (!flush && !stall && !hold_full && !resp && fetch_bubbles != '1)
         fetch_bubbles <= fetch_bubbles + 32'd1;
   end
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 3-stage core. Sits directly upstream of the hazard/forward unit and produces the F/D pipeline register (ir_FD, pc_FD) it inspects.
- Owns the PC and a single-outstanding request/response handshake to instruction memory.
- Consumes stall and flush (branch taken / mret) from the hazard unit, with the redirect target supplied by execute.

Parameters:
Width, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
stall  input  1  hold F/D register (from hazard unit)
flush  input  1  discard in-flight work, redirect PC
flush_pc  input  Width  redirect target, valid when flush=1
imem_req  output  1  fetch request valid
imem_addr  output  Width  fetch address (= pc_F)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  Width  instruction word
pc_F  output  Width  current fetch PC
ir_FD  output  Width  F/D instruction register
pc_FD  output  Width  F/D PC register
valid_FD  output  1  ir_FD holds a real instruction

Behaviour:
- Reset (async, rst=1): pc_F=RESET_PC, ir_FD=NOP, pc_FD=0, valid_FD=0, hold buffer empty, state=S_REQ, imem_req=0 while rst is high.
- State machine, states S_REQ, S_WAIT, S_DROP. At most one outstanding request.
- S_REQ:
  - imem_req = !hold_full && !flush.
  - On imem_req && imem_ready: pc_F <= pc_F+4 (mod 2^Width, wraps), next state S_WAIT.
- S_WAIT:
  - imem_req=0.
  - On imem_rvalid: the word is delivered (see delivery rules), next state S_REQ.
- S_DROP:
  - imem_req=0.
  - On imem_rvalid: the word is discarded, next state S_REQ.
- Delivery (each cycle the F/D register is not stalled):
  - Hold buffer non-empty: F/D <= hold, valid_FD=1, hold emptied.
  - Otherwise, imem_rvalid in S_WAIT: F/D <= {imem_rdata, address of that request}, valid_FD=1.
  - Otherwise: ir_FD<=NOP, valid_FD<=0 (bubble); pc_FD unchanged.
- Stall:
  - F/D registers hold their values.
  - A response arriving in S_WAIT is written into the 1-entry hold buffer together with its PC.
  - No new request is issued while the hold buffer is full.
- Flush (priority over stall and delivery):
  - pc_F <= flush_pc; ir_FD<=NOP, valid_FD<=0; hold buffer cleared.
  - In S_WAIT without rvalid this cycle: next state S_DROP.
  - In S_WAIT with rvalid this cycle: word dropped, next state S_REQ.
  - In S_REQ: imem_req forced 0, stays S_REQ.
  - In S_DROP: stays S_DROP until rvalid arrives.
- Throughput: one instruction per 2 cycles with a zero-wait memory (request cycle + response cycle). Latency from accepted request to ir_FD is 1 cycle after rvalid.
- imem_addr always equals pc_F; it is meaningful only when imem_req=1.
- Reset mid-transaction: FSM returns to S_REQ and the old response is not tracked. Memory must not assert rvalid for pre-reset requests after reset deasserts.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output port fetch_bubbles (32 bits), reset 0. It increments each cycle the F/D register loads a bubble for lack of data, excluding stall and flush cycles, and saturates at all-ones.
- Undefined: port and counter absent; other behaviour identical.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> imem_addr sequence 0,4,8 on request cycles; ir_FD=0,4,8 with valid_FD=1 on alternate cycles, NOP/valid_FD=0 in between.
- imem_ready low 3 cycles in S_REQ -> imem_req held 1, imem_addr stable at 0x0, pc_F unchanged, ir_FD=NOP.
- stall=1 for 4 cycles while response 0x00500093 arrives -> ir_FD unchanged during stall, no new imem_req; first cycle after stall drops, ir_FD=0x00500093, then fetch resumes at next PC.
- flush with flush_pc=0x100 while in S_WAIT, rvalid 2 cycles later -> that response discarded (ir_FD stays NOP), next imem_addr=0x100.
- flush and stall together with hold buffer full -> hold cleared, ir_FD=NOP, valid_FD=0, pc_F=flush_pc next cycle.
- rst asserted mid-S_WAIT -> outputs return to reset values immediately (async); after release first imem_addr=RESET_PC.
